// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers the per-digit {en, hex[3:0], dp} words of an 8-digit multiplexed 7-segment display
//   by watching its anode and cathode pins. Each digit is captured once per dwell, after its
//   pins have held still long enough. A digit that is not refreshed for a long time is marked
//   disabled.
// Ports:
//   clock         system clock
//   reset         asynchronous, active-low reset
//   an            anode enables, active-low; bit i selects digit i+1
//   dec_cat       cathodes, active-low; [7:1] = segments a..g, [0] = dp
//   d1..d8        recovered words {en, hex, dp}; d1 belongs to an[0]
//   digit_update  one-cycle pulse on every accepted capture (glyph or blank)
//   digit_idx     index of the last accepted capture
//   frame_done    one-cycle pulse when a capture index does not advance (scan wrapped)
//   seg_err       one-cycle pulse when a settled cathode pattern is not a font glyph
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned TO_W           = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] an,
  input  logic [7:0] dec_cat,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8,
  output logic       digit_update,
  output logic [2:0] digit_idx,
  output logic       frame_done,
  output logic       seg_err
);

  localparam logic [7:0]      SettleMax = 8'(SETTLE_CYCLES);
  // The capture fires on the transition into SETTLE_CYCLES-1.
  localparam logic [7:0]      SettleCap = SettleMax - 8'd2;
  localparam logic [TO_W-1:0] ToOne     = TO_W'(1);
  localparam logic [TO_W-1:0] ToMax     = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] ToLast    = ToMax - ToOne;

  // Input stage and stability tracking
  logic [7:0] r_an, r_cat;
  logic [7:0] r_an_prev, r_cat_prev;
  logic [7:0] r_cnt;

  // Output-side state
  logic [7:0][5:0]      r_d;
  logic [7:0][TO_W-1:0] r_to;
  logic                 r_update;
  logic [2:0]           r_idx;
  logic                 r_frame;
  logic                 r_err;
  logic [2:0]           r_prev_idx;

  logic                 w_same;
  logic [3:0]           w_zeros;
  logic [2:0]           w_sel_idx;
  logic                 w_sel_ok;
  logic [7:0]           w_cnt;
  logic                 w_capture;
  logic [6:0]           w_seg;
  logic                 w_hit;
  logic [3:0]           w_hex;
  logic                 w_blank;
  logic                 w_good;
  logic                 w_bad;
  logic [5:0]           w_word;
  logic [7:0][5:0]      w_d;
  logic [7:0][TO_W-1:0] w_to;

  assign w_same = ({r_an, r_cat} == {r_an_prev, r_cat_prev});

  // Digit select: exactly one anode low
  always_comb begin
    w_zeros   = 4'd0;
    w_sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!r_an[i]) begin
        w_zeros   = w_zeros + 4'd1;
        w_sel_idx = 3'(i);
      end
    end
    w_sel_ok = (w_zeros == 4'd1);
  end

  // Stability counter; held at zero while no single digit is selected
  always_comb begin
    w_cnt = r_cnt;
    if (!w_sel_ok || !w_same) begin
      w_cnt = 8'd0;
    end else if (r_cnt < SettleMax) begin
      w_cnt = r_cnt + 8'd1;
    end
  end

  assign w_capture = w_sel_ok && w_same && (r_cnt == SettleCap);

  // Font decode on active-high segments a..g (bit 6 = a)
  assign w_seg = ~r_cat[7:1];

  always_comb begin
    w_hit = 1'b1;
    w_hex = 4'h0;
    case (w_seg)
      7'b1111110: w_hex = 4'h0;
      7'b0110000: w_hex = 4'h1;
      7'b1101101: w_hex = 4'h2;
      7'b1111001: w_hex = 4'h3;
      7'b0110011: w_hex = 4'h4;
      7'b1011011: w_hex = 4'h5;
      7'b1011111: w_hex = 4'h6;
      7'b1110000: w_hex = 4'h7;
      7'b1111111: w_hex = 4'h8;
      7'b1111011: w_hex = 4'h9;
      7'b1110111: w_hex = 4'hA;
      7'b0011111: w_hex = 4'hB;
      7'b1001110: w_hex = 4'hC;
      7'b0111101: w_hex = 4'hD;
      7'b1001111: w_hex = 4'hE;
      7'b1000111: w_hex = 4'hF;
      default:    w_hit = 1'b0;
    endcase
  end

  assign w_blank = (w_seg == 7'd0);
  assign w_good  = w_capture && (w_hit || w_blank);
  assign w_bad   = w_capture && !w_hit && !w_blank;
  assign w_word  = w_hit ? {1'b1, w_hex, ~r_cat[0]} : {1'b0, 4'h0, ~r_cat[0]};

  // Per-digit timeout and capture; capture is applied last so it wins over a same-cycle timeout
  always_comb begin
    w_d  = r_d;
    w_to = r_to;
    for (int i = 0; i < 8; i++) begin
      if (r_to[i] != ToMax) begin
        w_to[i] = r_to[i] + ToOne;
        if (r_to[i] == ToLast) begin
          w_d[i][5] = 1'b0;
        end
      end
      if (w_good && (w_sel_idx == 3'(i))) begin
        w_d[i]  = w_word;
        w_to[i] = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_an       <= 8'hFF;
      r_cat      <= 8'hFF;
      r_an_prev  <= 8'hFF;
      r_cat_prev <= 8'hFF;
      r_cnt      <= 8'd0;
      r_d        <= '0;
      r_to       <= '0;
      r_update   <= 1'b0;
      r_idx      <= 3'd0;
      r_frame    <= 1'b0;
      r_err      <= 1'b0;
      r_prev_idx <= 3'd7;
    end else begin
      r_an       <= an;
      r_cat      <= dec_cat;
      r_an_prev  <= r_an;
      r_cat_prev <= r_cat;
      r_cnt      <= w_cnt;
      r_d        <= w_d;
      r_to       <= w_to;
      r_update   <= w_good;
      r_frame    <= w_good && (w_sel_idx <= r_prev_idx);
      r_err      <= w_bad;
      if (w_good) begin
        r_idx      <= w_sel_idx;
        r_prev_idx <= w_sel_idx;
      end
    end
  end

  assign d1           = r_d[0];
  assign d2           = r_d[1];
  assign d3           = r_d[2];
  assign d4           = r_d[3];
  assign d5           = r_d[4];
  assign d6           = r_d[5];
  assign d7           = r_d[6];
  assign d8           = r_d[7];
  assign digit_update = r_update;
  assign digit_idx    = r_idx;
  assign frame_done   = r_frame;
  assign seg_err      = r_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed sequence with random data, checked every cycle against a
// run-length reference model of the display monitor.
module tb_seg_scan_decoder;

  localparam int Settle  = 4;
  localparam int Timeout = 1000;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] an      = 8'hFF;
  logic [7:0] dec_cat = 8'hFF;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       digit_update, frame_done, seg_err;
  logic [2:0] digit_idx;

  seg_scan_decoder #(
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Timeout),
    .TO_W          (21)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .an          (an),
    .dec_cat     (dec_cat),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .d5          (d5),
    .d6          (d6),
    .d7          (d7),
    .d8          (d8),
    .digit_update(digit_update),
    .digit_idx   (digit_idx),
    .frame_done  (frame_done),
    .seg_err     (seg_err)
  );

  always #5 clock = ~clock;

  // Active-high a..g glyphs for hex 0..F
  logic [6:0] font [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_upd   = 0;
  int n_frame = 0;
  int n_err   = 0;
  int cap7_cyc = -1;
  int drop_cyc = -1;
  logic d8_en_prev = 1'b0;

  // Reference model state
  logic [5:0]  m_d [8];
  int          m_age [8];
  logic        m_upd, m_frame, m_err;
  logic [2:0]  m_idx, m_prev;
  logic [15:0] m_last;
  int          m_run;
  logic        m_pend;
  logic [15:0] m_pend_pins;

  logic [5:0] drv [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [5:0] w);
    logic [6:0] g;
    g = font[w[4:1]];
    return w[5] ? {~g, ~w[0]} : {7'h7F, ~w[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_d[i]   = 6'd0;
      m_age[i] = 0;
    end
    m_upd = 1'b0; m_frame = 1'b0; m_err = 1'b0;
    m_idx = 3'd0; m_prev = 3'd7;
    m_last = 16'hFFFF; m_run = 0;
    m_pend = 1'b0; m_pend_pins = 16'hFFFF;
  endtask

  // One clock edge: apply what settled on the previous edge, then take the new pin sample.
  task automatic model_step(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] pa, pc;
    logic [6:0] seg;
    int         idx;
    int         hx;
    logic       hit;
    m_upd = 1'b0; m_frame = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m_age[i] < Timeout) begin
        m_age[i]++;
        if (m_age[i] == Timeout) m_d[i][5] = 1'b0;
      end
    end
    if (m_pend) begin
      pa  = m_pend_pins[15:8];
      pc  = m_pend_pins[7:0];
      idx = 0;
      for (int j = 0; j < 8; j++) if (!pa[j]) idx = j;
      seg = ~pc[7:1];
      hit = 1'b0;
      hx  = 0;
      for (int j = 0; j < 16; j++) if (font[j] == seg) begin hit = 1'b1; hx = j; end
      if (hit || seg == 7'd0) begin
        m_d[idx]   = hit ? {1'b1, 4'(hx), ~pc[0]} : {1'b0, 4'h0, ~pc[0]};
        m_age[idx] = 0;
        m_upd      = 1'b1;
        m_frame    = (3'(idx) <= m_prev);
        m_prev     = 3'(idx);
        m_idx      = 3'(idx);
      end else begin
        m_err = 1'b1;
      end
    end
    if ({a, c} == m_last) begin
      if (m_run < 100000) m_run++;
    end else begin
      m_run = 1;
    end
    m_last      = {a, c};
    m_pend      = (m_run == Settle) && ($countones(~a) == 1);
    m_pend_pins = {a, c};
  endtask

  task automatic check_all();
    chk("digits", {d8, d7, d6, d5, d4, d3, d2, d1},
        {m_d[7], m_d[6], m_d[5], m_d[4], m_d[3], m_d[2], m_d[1], m_d[0]});
    chk("pulses", {digit_update, digit_idx, frame_done, seg_err}, {m_upd, m_idx, m_frame, m_err});
  endtask

  // Pins are only changed just after a falling edge, so the rising edge in between saw them.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (reset) model_step(an, dec_cat);
    else model_reset();
    check_all();
    if (digit_update) n_upd++;
    if (frame_done) n_frame++;
    if (seg_err) n_err++;
    if (digit_update && digit_idx == 3'd7) cap7_cyc = cyc;
    if (d8_en_prev && !d8[5]) drop_cyc = cyc;
    d8_en_prev = d8[5];
  endtask

  task automatic hold(input logic [7:0] a, input logic [7:0] c, input int n);
    an      = a;
    dec_cat = c;
    repeat (n) tick();
  endtask

  initial begin
    logic [7:0] pat, prev_pat;
    logic [5:0] w;
    logic [5:0] w7;
    logic [5:0] w3;
    model_reset();

    // Reset hold with random pins
    for (int i = 0; i < 5; i++) hold(8'($urandom), 8'($urandom), 1);
    chk("rst_digits", {d8, d7, d6, d5, d4, d3, d2, d1}, 64'd0);
    chk("rst_pulses", {digit_update, frame_done, seg_err, digit_idx}, 64'd0);
    reset = 1'b1;

    // No digit selected
    n_upd = 0;
    for (int i = 0; i < 100; i++) hold(8'hFF, 8'($urandom), 1);
    chk("idle_no_update", n_upd, 0);

    // Single digit "0", dp off: visible exactly after the 5th edge of the dwell
    hold(8'hFE, 8'b0000_0011, 4);
    chk("single_early", {digit_update, d1}, 64'd0);
    hold(8'hFE, 8'b0000_0011, 1);
    chk("single_d1", d1, 6'b1_0000_0);
    chk("single_upd", {digit_update, digit_idx}, {1'b1, 3'd0});
    hold(8'hFE, 8'b0000_0011, 3);
    chk("single_pulse_once", digit_update, 1'b0);

    // Glitch rejection on digit 2, then settled "A" with dp on
    n_upd    = 0;
    prev_pat = 8'h00;
    for (int i = 0; i < 10; i++) begin
      pat = 8'($urandom);
      if (pat == prev_pat) pat = pat ^ 8'h02;
      prev_pat = pat;
      hold(8'hFD, pat, 3);
    end
    chk("glitch_no_update", n_upd, 0);
    chk("glitch_d2", d2, 6'd0);
    hold(8'hFD, 8'b0001_0000, 6);
    chk("glitch_d2_A", d2, 6'b1_1010_1);

    // Full scan of all 8 digits, three rounds
    drv[0] = {1'b1, 4'h3, 1'b0};
    drv[1] = {1'b1, 4'h9, 1'b0};
    for (int i = 2; i < 8; i++) drv[i] = {1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
    drv[5] = {1'b0, 4'h0, 1'($urandom_range(0, 1))};
    n_frame = 0; n_err = 0; n_upd = 0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin
        hold(~(8'h01 << k), enc(drv[k]), $urandom_range(Settle, 9));
        if ($urandom_range(0, 1) == 1) hold(8'hFF, 8'hFF, 1);
      end
    end
    hold(8'hFF, 8'hFF, 2);
    chk("scan_words", {d8, d7, d6, d5, d4, d3, d2, d1},
        {drv[7], drv[6], drv[5], drv[4], drv[3], drv[2], drv[1], drv[0]});
    chk("scan_frames", n_frame, 3);
    chk("scan_no_err", n_err, 0);
    chk("scan_updates", n_upd, 24);

    // Bad pattern on digit 5, then blank
    n_err = 0; n_upd = 0;
    hold(8'hEF, 8'b1010_1011, 6);
    chk("bad_err_once", n_err, 1);
    chk("bad_no_update", n_upd, 0);
    chk("bad_d5_kept", d5, drv[4]);
    hold(8'hEF, 8'hFF, 6);
    chk("blank_d5", d5, 6'b0_0000_0);

    // Reset in the middle of a dwell needs a full dwell afterwards
    w3 = {1'b1, 4'h5, 1'b0};
    hold(8'hF7, enc(w3), 2);
    reset = 1'b0;
    hold(8'hF7, enc(w3), 2);
    chk("midrst_clear", {d8, d7, d6, d5, d4, d3, d2, d1}, 64'd0);
    reset = 1'b1;
    n_upd = 0;
    hold(8'hF7, enc(w3), 4);
    chk("midrst_early", n_upd, 0);
    hold(8'hF7, enc(w3), 1);
    chk("midrst_d4", d4, w3);
    chk("midrst_frame", {digit_update, frame_done, digit_idx}, {1'b1, 1'b1, 3'd3});

    // Timeout on digit 8 while digit 1 keeps refreshing
    w7 = {1'b1, 4'hC, 1'b1};
    cap7_cyc = -1; drop_cyc = -1;
    hold(8'h7F, enc(w7), 5);
    chk("to_cap7", d8, w7);
    n_upd = 0;
    for (int i = 0; i < 200; i++) begin
      w = {1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
      hold(8'hFE, enc(w), 5);
      chk("to_d1_refresh", d1, w);
      hold(8'hFF, 8'hFF, 1);
    end
    chk("to_delay", drop_cyc - cap7_cyc, Timeout);
    chk("to_d8_kept", d8, {1'b0, w7[4:0]});
    chk("to_d1_updates", n_upd, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
